rob_alloc_ctrl: RTL and testbench

ROB_ALLOC_CTRL -- requirements
Module: rob_alloc_ctrl

---
 rtl/rob_alloc_ctrl.sv | 137 +++++++++++++
 tb/tb_rob_alloc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation controller: head/tail/count tracking, branch checkpoint slots,
// and single-edge mispredict recovery that squashes the mispredicted branch and all younger ones.
module rob_alloc_ctrl #(
    parameter int ROB_BITS   = 4,
    parameter int CKPT_SLOTS = 4,
    parameter int CKPT_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dispatch_valid,
    input  logic                  dispatch_is_branch,
    output logic                  dispatch_ready,
    output logic [ROB_BITS-1:0]   dispatch_tag,
    output logic [CKPT_BITS-1:0]  dispatch_ckpt_id,
    input  logic                  retire_en,
    output logic [ROB_BITS-1:0]   retire_tag,
    input  logic                  resolve_en,
    input  logic [CKPT_BITS-1:0]  resolve_id,
    input  logic                  resolve_mispredict,
    output logic [ROB_BITS:0]     rob_count,
    output logic                  rob_full,
    output logic                  rob_empty,
    output logic [CKPT_SLOTS-1:0] ckpt_free
);

    localparam logic [ROB_BITS:0]   DEPTH   = (ROB_BITS+1)'(2 ** ROB_BITS);
    localparam logic [ROB_BITS:0]   CNT_ONE = (ROB_BITS+1)'(1);
    localparam logic [ROB_BITS-1:0] PTR_ONE = ROB_BITS'(1);

    logic [ROB_BITS-1:0]   head_q, head_d;
    logic [ROB_BITS-1:0]   tail_q, tail_d;
    logic [ROB_BITS:0]     count_q, count_d;
    logic [CKPT_SLOTS-1:0] ckpt_valid_q, ckpt_valid_d;
    logic [ROB_BITS-1:0]   ckpt_tag_q   [CKPT_SLOTS];
    logic [ROB_BITS-1:0]   ckpt_tag_d   [CKPT_SLOTS];
    logic [CKPT_SLOTS-1:0] ckpt_older_q [CKPT_SLOTS];
    logic [CKPT_SLOTS-1:0] ckpt_older_d [CKPT_SLOTS];

    logic [CKPT_BITS-1:0]  alloc_id;
    logic                  any_free;
    logic                  mispredict_req;
    logic                  dispatch_fire;
    logic                  branch_fire;
    logic                  retire_fire;
    logic                  resolve_hit;
    logic                  resolve_ok;
    logic                  resolve_bad;
    logic [CKPT_SLOTS-1:0] freed;
    logic [ROB_BITS-1:0]   span;

    assign rob_full         = (count_q == DEPTH);
    assign rob_empty        = (count_q == '0);
    assign rob_count        = count_q;
    assign ckpt_free        = ~ckpt_valid_q;
    assign any_free         = |ckpt_free;
    assign dispatch_tag     = tail_q;
    assign retire_tag       = head_q;
    assign dispatch_ckpt_id = alloc_id;

    // Lowest-indexed free slot, scanned from the top so the lowest index wins.
    always_comb begin
        alloc_id = '0;
        for (int i = CKPT_SLOTS - 1; i >= 0; i--) begin
            if (!ckpt_valid_q[i]) alloc_id = CKPT_BITS'(i);
        end
    end

    assign mispredict_req = resolve_en && resolve_mispredict;
    assign dispatch_ready = !rob_full && !mispredict_req && (!dispatch_is_branch || any_free);
    assign dispatch_fire  = dispatch_valid && dispatch_ready;
    assign branch_fire    = dispatch_fire && dispatch_is_branch;
    assign retire_fire    = retire_en && !rob_empty;
    assign resolve_hit    = resolve_en && ckpt_valid_q[resolve_id];
    assign resolve_ok     = resolve_hit && !resolve_mispredict;
    assign resolve_bad    = resolve_hit && resolve_mispredict;
    assign span           = ckpt_tag_q[resolve_id] - head_q;

    // A mispredict frees the slot itself plus every slot that recorded it as older.
    always_comb begin
        freed = '0;
        if (resolve_ok) begin
            freed[resolve_id] = 1'b1;
        end else if (resolve_bad) begin
            for (int k = 0; k < CKPT_SLOTS; k++) freed[k] = ckpt_older_q[k][resolve_id];
            freed[resolve_id] = 1'b1;
        end
    end

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        ckpt_valid_d = ckpt_valid_q & ~freed;
        ckpt_tag_d   = ckpt_tag_q;
        for (int k = 0; k < CKPT_SLOTS; k++) ckpt_older_d[k] = ckpt_older_q[k] & ~freed;

        if (retire_fire) head_d = head_q + PTR_ONE;

        if (resolve_bad) begin
            tail_d  = ckpt_tag_q[resolve_id] + PTR_ONE;
            count_d = {1'b0, span} + CNT_ONE - (retire_fire ? CNT_ONE : '0);
        end else begin
            if (dispatch_fire) tail_d = tail_q + PTR_ONE;
            count_d = count_q + (dispatch_fire ? CNT_ONE : '0) - (retire_fire ? CNT_ONE : '0);
        end

        // Branch capture uses the pre-edge valid vector, minus anything resolving this cycle.
        if (branch_fire) begin
            ckpt_valid_d[alloc_id] = 1'b1;
            ckpt_tag_d[alloc_id]   = tail_q;
            ckpt_older_d[alloc_id] = ckpt_valid_q & ~freed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            ckpt_valid_q <= '0;
            for (int k = 0; k < CKPT_SLOTS; k++) begin
                ckpt_tag_q[k]   <= '0;
                ckpt_older_q[k] <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            ckpt_valid_q <= ckpt_valid_d;
            for (int k = 0; k < CKPT_SLOTS; k++) begin
                ckpt_tag_q[k]   <= ckpt_tag_d[k];
                ckpt_older_q[k] <= ckpt_older_d[k];
            end
        end
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl: a vector table for basic flow plus hand-written
// sequences for fill/wrap, checkpoint exhaustion, nested and out-of-order recovery, reset.
module tb_rob_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       dispatch_valid, dispatch_is_branch, dispatch_ready;
    logic [3:0] dispatch_tag;
    logic [1:0] dispatch_ckpt_id;
    logic       retire_en;
    logic [3:0] retire_tag;
    logic       resolve_en;
    logic [1:0] resolve_id;
    logic       resolve_mispredict;
    logic [4:0] rob_count;
    logic       rob_full, rob_empty;
    logic [3:0] ckpt_free;

    int n_chk = 0;
    int n_bad = 0;

    rob_alloc_ctrl #(.ROB_BITS(4), .CKPT_SLOTS(4), .CKPT_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_is_branch(dispatch_is_branch),
        .dispatch_ready(dispatch_ready), .dispatch_tag(dispatch_tag),
        .dispatch_ckpt_id(dispatch_ckpt_id), .retire_en(retire_en), .retire_tag(retire_tag),
        .resolve_en(resolve_en), .resolve_id(resolve_id), .resolve_mispredict(resolve_mispredict),
        .rob_count(rob_count), .rob_full(rob_full), .rob_empty(rob_empty), .ckpt_free(ckpt_free)
    );

    always #5 clk = ~clk;

    // Input byte: [7] rst [6] dispatch_valid [5] is_branch [4] retire [3] resolve [2:1] id [0] mispredict
    localparam logic [7:0] RST = 8'h80, DV = 8'h40, BR = 8'h20, RET = 8'h10, REN = 8'h08, MIS = 8'h01;

    typedef struct {
        logic [7:0] in;
        logic [3:0] tag;
        logic [1:0] cid;
        logic [3:0] rtag;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic [3:0] free;
        logic       rdy;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [7:0] rid(input int r);
        return 8'(r * 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; checks that follow see pre-edge state.
    task automatic cyc(input logic [7:0] in);
        @(negedge clk);
        rst                = in[7];
        dispatch_valid     = in[6];
        dispatch_is_branch = in[5];
        retire_en          = in[4];
        resolve_en         = in[3];
        resolve_id         = in[2:1];
        resolve_mispredict = in[0];
        #1;
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, ".tag"},   32'(dispatch_tag), 0);
        chk({tagname, ".rtag"},  32'(retire_tag), 0);
        chk({tagname, ".cnt"},   32'(rob_count), 0);
        chk({tagname, ".empty"}, 32'(rob_empty), 1);
        chk({tagname, ".full"},  32'(rob_full), 0);
        chk({tagname, ".cid"},   32'(dispatch_ckpt_id), 0);
        chk({tagname, ".free"},  32'(ckpt_free), 32'hF);
        chk({tagname, ".rdy"},   32'(dispatch_ready), 1);
    endtask

    // Branches at tags 2 (slot0), 5 (slot1), 7 (slot2); tail ends at 9.
    task automatic nested_setup(input string nm);
        cyc(RST);
        for (int i = 0; i < 9; i++) begin
            cyc(DV | ((i == 2 || i == 5 || i == 7) ? BR : 8'h00));
            chk({nm, ".setup_tag"}, 32'(dispatch_tag), 32'(i));
        end
    endtask

    initial begin
        vecs[0]  = '{RST | DV,             4'd0, 2'd0, 4'd0, 5'd0, 1'b0, 1'b1, 4'hF, 1'b1};
        vecs[1]  = '{DV,                   4'd0, 2'd0, 4'd0, 5'd0, 1'b0, 1'b1, 4'hF, 1'b1};
        vecs[2]  = '{DV | BR,              4'd1, 2'd0, 4'd0, 5'd1, 1'b0, 1'b0, 4'hF, 1'b1};
        vecs[3]  = '{DV | BR,              4'd2, 2'd1, 4'd0, 5'd2, 1'b0, 1'b0, 4'hE, 1'b1};
        vecs[4]  = '{DV | RET,             4'd3, 2'd2, 4'd0, 5'd3, 1'b0, 1'b0, 4'hC, 1'b1};
        vecs[5]  = '{DV | BR | REN | 8'h02, 4'd4, 2'd2, 4'd1, 5'd3, 1'b0, 1'b0, 4'hC, 1'b1};
        vecs[6]  = '{REN | 8'h06 | MIS,    4'd5, 2'd1, 4'd1, 5'd4, 1'b0, 1'b0, 4'hA, 1'b0};
        vecs[7]  = '{DV | BR | REN | MIS,  4'd5, 2'd1, 4'd1, 5'd4, 1'b0, 1'b0, 4'hA, 1'b0};
        vecs[8]  = '{DV | BR,              4'd2, 2'd0, 4'd1, 5'd1, 1'b0, 1'b0, 4'hF, 1'b1};
        vecs[9]  = '{RET | REN,            4'd3, 2'd1, 4'd1, 5'd2, 1'b0, 1'b0, 4'hE, 1'b1};
        vecs[10] = '{RET,                  4'd3, 2'd0, 4'd2, 5'd1, 1'b0, 1'b0, 4'hF, 1'b1};
        vecs[11] = '{RET,                  4'd3, 2'd0, 4'd3, 5'd0, 1'b0, 1'b1, 4'hF, 1'b1};
        vecs[12] = '{8'h00,                4'd3, 2'd0, 4'd3, 5'd0, 1'b0, 1'b1, 4'hF, 1'b1};

        cyc(RST);
        cyc(RST);
        for (int v = 0; v < 13; v++) begin
            cyc(vecs[v].in);
            chk($sformatf("v%0d.tag", v),   32'(dispatch_tag),     32'(vecs[v].tag));
            chk($sformatf("v%0d.cid", v),   32'(dispatch_ckpt_id), 32'(vecs[v].cid));
            chk($sformatf("v%0d.rtag", v),  32'(retire_tag),       32'(vecs[v].rtag));
            chk($sformatf("v%0d.cnt", v),   32'(rob_count),        32'(vecs[v].cnt));
            chk($sformatf("v%0d.full", v),  32'(rob_full),         32'(vecs[v].full));
            chk($sformatf("v%0d.empty", v), 32'(rob_empty),        32'(vecs[v].empty));
            chk($sformatf("v%0d.free", v),  32'(ckpt_free),        32'(vecs[v].free));
            chk($sformatf("v%0d.rdy", v),   32'(dispatch_ready),   32'(vecs[v].rdy));
        end

        // Fill to 16, then wrap the tail after one retire.
        cyc(RST);
        for (int i = 0; i < 16; i++) begin
            cyc(DV);
            chk("fill.tag", 32'(dispatch_tag), 32'(i));
            chk("fill.rdy", 32'(dispatch_ready), 1);
        end
        cyc(DV);
        chk("fill.full", 32'(rob_full), 1);
        chk("fill.cnt16", 32'(rob_count), 16);
        chk("fill.rdy_full", 32'(dispatch_ready), 0);
        cyc(RET);
        chk("fill.still_full", 32'(rob_full), 1);
        cyc(DV);
        chk("wrap.cnt", 32'(rob_count), 15);
        chk("wrap.tag", 32'(dispatch_tag), 0);
        chk("wrap.rtag", 32'(retire_tag), 1);
        chk("wrap.rdy", 32'(dispatch_ready), 1);
        cyc(8'h00);
        chk("wrap.refill_cnt", 32'(rob_count), 16);
        chk("wrap.refill_tag", 32'(dispatch_tag), 1);

        // Simultaneous dispatch and retire at count 5.
        cyc(RST);
        for (int i = 0; i < 5; i++) cyc(DV);
        cyc(DV | RET);
        chk("simul.pre_cnt", 32'(rob_count), 5);
        cyc(8'h00);
        chk("simul.cnt", 32'(rob_count), 5);
        chk("simul.rtag", 32'(retire_tag), 1);
        chk("simul.tag", 32'(dispatch_tag), 6);

        // Checkpoint exhaustion: branch stalls, plain instruction proceeds.
        cyc(RST);
        for (int i = 0; i < 4; i++) begin
            cyc(DV | BR);
            chk("ckpt.cid", 32'(dispatch_ckpt_id), 32'(i));
            chk("ckpt.rdy", 32'(dispatch_ready), 1);
        end
        cyc(DV | BR);
        chk("ckpt.free0", 32'(ckpt_free), 0);
        chk("ckpt.br_stall", 32'(dispatch_ready), 0);
        cyc(DV);
        chk("ckpt.plain_rdy", 32'(dispatch_ready), 1);
        chk("ckpt.no_fire_cnt", 32'(rob_count), 4);
        cyc(8'h00);
        chk("ckpt.plain_cnt", 32'(rob_count), 5);
        chk("ckpt.plain_tag", 32'(dispatch_tag), 5);

        // Nested mispredict on the oldest branch.
        nested_setup("nest");
        cyc(REN | rid(0) | MIS);
        chk("nest.pre_tag", 32'(dispatch_tag), 9);
        chk("nest.pre_cnt", 32'(rob_count), 9);
        chk("nest.pre_free", 32'(ckpt_free), 32'h8);
        chk("nest.rdy_mis", 32'(dispatch_ready), 0);
        cyc(DV);
        chk("nest.tag", 32'(dispatch_tag), 3);
        chk("nest.cnt", 32'(rob_count), 3);
        chk("nest.free", 32'(ckpt_free), 32'hF);
        chk("nest.rdy", 32'(dispatch_ready), 1);
        cyc(8'h00);
        chk("nest.next_tag", 32'(dispatch_tag), 4);
        chk("nest.next_cnt", 32'(rob_count), 4);

        // Out-of-order resolve: slot1 correct, then slot0 mispredict.
        nested_setup("ooo");
        cyc(REN | rid(1));
        cyc(REN | rid(0) | MIS);
        chk("ooo.after_ok_free", 32'(ckpt_free), 32'hA);
        cyc(DV | BR);
        chk("ooo.free", 32'(ckpt_free), 32'hF);
        chk("ooo.tag", 32'(dispatch_tag), 3);
        chk("ooo.cnt", 32'(rob_count), 3);
        chk("ooo.cid0", 32'(dispatch_ckpt_id), 0);
        cyc(DV | BR);
        chk("ooo.cid1", 32'(dispatch_ckpt_id), 1);
        chk("ooo.tag4", 32'(dispatch_tag), 4);
        cyc(REN | rid(1) | MIS);
        chk("ooo.pre_free", 32'(ckpt_free), 32'hC);
        cyc(8'h00);
        chk("ooo.stale_free", 32'(ckpt_free), 32'hE);
        chk("ooo.stale_cnt", 32'(rob_count), 5);
        chk("ooo.stale_tag", 32'(dispatch_tag), 5);

        // Reset mid-operation wins over concurrent activity.
        cyc(RST);
        for (int i = 0; i < 10; i++) cyc(DV | ((i == 3) ? BR : 8'h00));
        cyc(RST | DV | RET | REN | rid(0) | MIS);
        chk("rstmid.pre_cnt", 32'(rob_count), 10);
        cyc(DV | BR);
        chk_reset_outputs("rstmid");

        cyc(8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
